mfp_spi_lcd_master: RTL and testbench

Parametrised, write-only SPI master for the board LCD, the next generation of the fixed SDO/RS/SCK port set on the Nexys4 DDR system.
- Adds a transmit FIFO, per-word RS (data/command) select, a programmable SCK divider, and chip-select framing across multi-word bursts.
- Sits between the AHB GPIO/LCD register slave (write side) and the board SPI pins.
- Operates in SPI mode 0 only: SCK idles low, MSB first.

---
 rtl/mfp_spi_lcd_master_pkg.sv | 18 +
 rtl/mfp_sync_fifo.sv | 58 +++++
 rtl/mfp_spi_lcd_master.sv | 176 +++++++++++++++++
 tb/tb_mfp_spi_lcd_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_spi_lcd_master_pkg.sv
// Shared constants and FSM encoding for the LCD SPI master.
package mfp_spi_lcd_master_pkg;

    // Default word width and TX FIFO depth for the board LCD link.
    localparam int MFP_SPI_DATA_W     = 8;
    localparam int MFP_SPI_FIFO_DEPTH = 16;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

endpackage

// File: rtl/mfp_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and show-ahead read.
// Generic so it can be shared with other serial transmit paths.
module mfp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; an empty count makes stale contents unreachable.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mfp_spi_lcd_master.sv
// Write-only SPI mode-0 master for the board LCD: TX FIFO of {last, rs, data}
// entries, programmable SCK half-period, CS held low across multi-word bursts.
module mfp_spi_lcd_master
    import mfp_spi_lcd_master_pkg::*;
#(
    parameter int DATA_W     = MFP_SPI_DATA_W,
    parameter int FIFO_DEPTH = MFP_SPI_FIFO_DEPTH,
    parameter int DIV_W      = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_rs,
    input  logic                          wr_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          SPI_SCK,
    output logic                          SPI_SDO,
    output logic                          SPI_RS,
    output logic                          SPI_CS_N
);

    localparam int EW = DATA_W + 2;
    localparam int HW = $clog2(2 * DATA_W);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [EW-1:0]     pop_data;

    spi_state_t        state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [HW-1:0]     half_cnt;
    logic [DATA_W-1:0] shreg;
    logic              last_q;
    logic              sck_q;
    logic              sdo_q;
    logic              rs_q;
    logic              cs_n_q;
    logic              busy_q;

    assign wr_ready = !fifo_full;
    assign busy     = busy_q;
    assign SPI_SCK  = sck_q;
    assign SPI_SDO  = sdo_q;
    assign SPI_RS   = rs_q;
    assign SPI_CS_N = cs_n_q;

    mfp_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (wr_valid),
        .push_data ({wr_last, wr_rs, wr_data}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Pop decision: start a word from IDLE/WAIT, or chain one at the end of HOLD inside a burst.
    always_comb begin
        // NOTE: default assigned first so no path leaves pop unassigned and infers a latch.
        pop = 1'b0;
        if (enable && !fifo_empty) begin
            case (state)
                ST_IDLE, ST_WAIT: pop = 1'b1;
                ST_HOLD:          pop = (cnt == '0) && !last_q;
                default:          pop = 1'b0;
            endcase
        end
    end

    // Frame sequencer with registered pin outputs; every phase lasts clk_div+1 cycles (latched at pop).
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            cnt      <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            rs_q     <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else if (pop) begin
            // Load the next entry; RS and the first data bit are presented during SETUP.
            state  <= ST_SETUP;
            div_q  <= clk_div;
            cnt    <= clk_div;
            shreg  <= pop_data[DATA_W-1:0];
            rs_q   <= pop_data[DATA_W];
            last_q <= pop_data[DATA_W+1];
            sdo_q  <= pop_data[DATA_W-1];
            sck_q  <= 1'b0;
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    sck_q  <= 1'b0;
                    cs_n_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        state    <= ST_SHIFT;
                        sck_q    <= 1'b1;
                        cnt      <= div_q;
                        half_cnt <= HALF_LAST;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        cnt <= div_q;
                        if (half_cnt == '0) begin
                            // Final low half done; SCK is already low.
                            state <= ST_HOLD;
                        end else begin
                            half_cnt <= half_cnt - HW'(1);
                            sck_q    <= ~sck_q;
                            // Advance data on falling edges, except after the LSB, which is held.
                            if (sck_q && half_cnt != HW'(1)) begin
                                shreg <= shreg << 1;
                                sdo_q <= shreg[DATA_W-2];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else if (last_q || !enable) begin
                        state  <= ST_GAP;
                        cs_n_q <= 1'b1;
                        cnt    <= div_q;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state  <= ST_GAP;
                        cs_n_q <= 1'b1;
                        cnt    <= div_q;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_spi_lcd_master.sv
// Directed self-checking bench for mfp_spi_lcd_master (default parameters).
module tb_mfp_spi_lcd_master;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       enable;
    logic [7:0] clk_div;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_rs;
    logic       wr_last;
    logic [4:0] fifo_level;
    logic       busy;
    logic       SPI_SCK;
    logic       SPI_SDO;
    logic       SPI_RS;
    logic       SPI_CS_N;

    int n_tests = 0;
    int n_fail  = 0;

    mfp_spi_lcd_master dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .enable     (enable),
        .clk_div    (clk_div),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_rs      (wr_rs),
        .wr_last    (wr_last),
        .fifo_level (fifo_level),
        .busy       (busy),
        .SPI_SCK    (SPI_SCK),
        .SPI_SDO    (SPI_SDO),
        .SPI_RS     (SPI_RS),
        .SPI_CS_N   (SPI_CS_N)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the push lands on the following rising edge.
    task automatic push(input logic [7:0] d, input logic rs, input logic last, output logic acc);
        wr_data  = d;
        wr_rs    = rs;
        wr_last  = last;
        wr_valid = 1'b1;
        acc      = wr_ready;
        @(negedge HCLK);
        wr_valid = 1'b0;
    endtask

    // Waits for CS_N low, then records one CS-low window sample by sample.
    task automatic capture_frame(output int start_dly, output int low, output logic [63:0] bits,
                                 output int nbits, output logic rs_first, output logic rs_last,
                                 output int hi_len, output int lo_len);
        logic prev_sck;
        logic seen_hi;
        int   run;
        start_dly = 0; low = 0; bits = '0; nbits = 0; hi_len = 0; lo_len = 0;
        rs_first = 1'bx; rs_last = 1'bx;
        @(negedge HCLK);
        while (SPI_CS_N !== 1'b0 && start_dly < 200) begin
            start_dly++;
            @(negedge HCLK);
        end
        if (SPI_CS_N !== 1'b0) begin
            check("frame_start_timeout", SPI_CS_N, 1'b0);
            return;
        end
        rs_first = SPI_RS;
        prev_sck = 1'b0;
        seen_hi  = 1'b0;
        run      = 0;
        while (SPI_CS_N === 1'b0 && low < 5000) begin
            low++;
            rs_last = SPI_RS;
            if (SPI_SCK && !prev_sck) begin
                bits = {bits[62:0], SPI_SDO};
                nbits++;
            end
            if (SPI_SCK == prev_sck) begin
                run++;
            end else begin
                if (prev_sck && hi_len == 0) hi_len = run;
                else if (!prev_sck && seen_hi && lo_len == 0) lo_len = run;
                run = 1;
            end
            if (SPI_SCK) seen_hi = 1'b1;
            prev_sck = SPI_SCK;
            @(negedge HCLK);
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while ((busy !== 1'b0 || fifo_level !== 5'd0) && g < 2000) begin
            @(negedge HCLK);
            g++;
        end
        check(tag, {busy, fifo_level}, 6'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sd, low, nb, hl, ll, highs, lows;
        logic [63:0] bits;
        logic        rsf, rsl, acc;
        int          accepted;

        HRESET = 1'b1; enable = 1'b0; clk_div = 8'd0;
        wr_valid = 1'b0; wr_data = 8'd0; wr_rs = 1'b0; wr_last = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_outputs", {SPI_SCK, SPI_SDO, SPI_RS, SPI_CS_N, busy}, 5'b00010);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rst_level", fifo_level, 5'd0);
        check("rst_wr_ready", wr_ready, 1'b1);

        // Single last word 0xA5, rs=1, div=0.
        enable = 1'b1;
        push(8'hA5, 1'b1, 1'b1, acc);
        check("a5_cs_before", SPI_CS_N, 1'b1);
        capture_frame(sd, low, bits, nb, rsf, rsl, hl, ll);
        check("a5_cs_fall_delay", sd, 0);
        check("a5_cs_low", low, 18);
        check("a5_bits", bits[7:0], 8'hA5);
        check("a5_nbits", nb, 8);
        check("a5_rs", {rsf, rsl}, 2'b11);
        check("a5_sck_phases", {hl[7:0], ll[7:0]}, {8'd1, 8'd1});
        check("a5_busy_gap", busy, 1'b1);
        @(negedge HCLK);
        check("a5_busy_idle", busy, 1'b0);

        // div=3, 0x3C; clk_div changed mid-word must not matter.
        clk_div = 8'd3;
        fork
            capture_frame(sd, low, bits, nb, rsf, rsl, hl, ll);
            begin
                push(8'h3C, 1'b0, 1'b1, acc);
                repeat (10) @(negedge HCLK);
                clk_div = 8'd0;
            end
        join
        check("3c_cs_low", low, 72);
        check("3c_bits", bits[7:0], 8'h3C);
        check("3c_sck_phases", {hl[7:0], ll[7:0]}, {8'd4, 8'd4});
        check("3c_rs", {rsf, rsl}, 2'b00);
        wait_idle("3c_idle");

        // Back-to-back burst 0x11 (rs0) then 0x22 (rs1, last).
        fork
            capture_frame(sd, low, bits, nb, rsf, rsl, hl, ll);
            begin
                push(8'h11, 1'b0, 1'b0, acc);
                push(8'h22, 1'b1, 1'b1, acc);
            end
        join
        check("burst_cs_low", low, 36);
        check("burst_bits", bits[15:0], 16'h1122);
        check("burst_nbits", nb, 16);
        check("burst_rs", {rsf, rsl}, 2'b01);
        wait_idle("burst_idle");

        // Word, 50-cycle stall in WAIT, then closing word.
        fork
            capture_frame(sd, low, bits, nb, rsf, rsl, hl, ll);
            begin
                push(8'h11, 1'b0, 1'b0, acc);
                repeat (50) @(negedge HCLK);
                check("wait_pins", {SPI_CS_N, SPI_SCK, busy}, 3'b001);
                push(8'h22, 1'b1, 1'b1, acc);
            end
        join
        check("wait_cs_low", low, 69);
        check("wait_bits", bits[15:0], 16'h1122);
        wait_idle("wait_idle");

        // Drop enable while in WAIT.
        fork
            capture_frame(sd, low, bits, nb, rsf, rsl, hl, ll);
            begin
                push(8'h33, 1'b1, 1'b0, acc);
                repeat (30) @(negedge HCLK);
                enable = 1'b0;
            end
        join
        check("drop_cs_low", low, 30);
        check("drop_bits", bits[7:0], 8'h33);
        check("drop_rs_held", rsl, 1'b1);
        wait_idle("drop_idle");

        // Fill with enable=0: 17 pushes, only 16 accepted.
        accepted = 0;
        for (int i = 0; i < 17; i++) begin
            push(8'h40 + 8'(i), 1'(i), 1'b1, acc);
            if (acc === 1'b1) accepted++;
        end
        check("full_accepted", accepted, 16);
        check("full_level", fifo_level, 5'd16);
        check("full_wr_ready", wr_ready, 1'b0);
        enable = 1'b1;
        @(negedge HCLK);
        check("full_after_pop", {wr_ready, fifo_level}, {1'b1, 5'd15});
        wait_idle("full_drain");

        // Async reset in the middle of SHIFT (bit 4 high phase).
        push(8'h5A, 1'b0, 1'b1, acc);
        push(8'hA5, 1'b1, 1'b1, acc);
        repeat (7) @(negedge HCLK);
        check("rst_mid_pre", {SPI_CS_N, SPI_SCK, SPI_SDO, fifo_level}, {3'b011, 5'd1});
        #1 HRESET = 1'b1;
        #1;
        check("rst_mid_pins", {SPI_CS_N, SPI_SCK, SPI_SDO, SPI_RS, busy}, 5'b10000);
        check("rst_mid_fifo", {wr_ready, fifo_level}, {1'b1, 5'd0});
        @(negedge HCLK);
        HRESET = 1'b0;
        highs = 0;
        lows  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            if (SPI_SCK !== 1'b0) highs++;
            if (SPI_CS_N !== 1'b1) lows++;
        end
        check("rst_no_residual_sck", highs, 0);
        check("rst_no_residual_cs", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
